// File: rtl/ov7670_capture_decimator_if.sv
// Camera parallel bus in, frame BRAM write port out.
// The camera side (master) drives D/vsync/href, and the capture block (slave) drives the write port.
interface ov7670_capture_decimator_if #(
    parameter int ADDR_W = 17
);
    logic [7:0]        D;
    logic              vsync;
    logic              href;
    logic [11:0]       RGB;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;

    modport master (output D, vsync, href, input RGB, wr_addr, wr_en);
    modport slave  (input D, vsync, href, output RGB, wr_addr, wr_en);
endinterface

// File: rtl/ov7670_capture_decimator.sv
// OV7670 RGB565 byte pairing, RGB444 reduction and frame-aligned decimated BRAM writes.
// Only frames that are seen from their vsync fall onwards are written.
module ov7670_capture_decimator #(
    parameter int SRC_W  = 640,
    parameter int SRC_H  = 480,
    parameter int DECIM  = 2,
    parameter int ADDR_W = 17
) (
    input  logic                      pclk,
    input  logic                      rst_n,
    ov7670_capture_decimator_if.slave bus,
    input  logic                      capture_en,
    output logic                      frame_done,
    output logic                      frame_active,
    output logic [7:0]                frame_count,
    output logic                      line_err
);
    localparam int FRAME_PIX = (SRC_W / DECIM) * (SRC_H / DECIM);
    localparam int COL_W     = $clog2(SRC_W + 2) + 1;
    localparam int ROW_W     = $clog2(SRC_H + 2) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

    typedef enum logic [1:0] {IDLE, SYNC, ARMED, CAPTURE} state_t;
    state_t state_reg, state_next;

    logic              vsync_reg, vsync_prev_reg, href_prev_reg;
    logic              phase_reg;
    logic [6:0]        byte0_reg;
    logic [COL_W-1:0]  col_reg;
    logic [ROW_W-1:0]  row_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic              wr_en_reg, full_reg;
    logic [11:0]       rgb_reg;
    logic              frame_done_reg, frame_active_reg, line_err_reg;
    logic [7:0]        frame_count_reg;

    logic vsync_rise, vsync_fall;
    logic enter_capture, close_frame, in_capture;
    logic pix_done, href_fall, decim_ok, keep;

    assign vsync_rise = vsync_reg & ~vsync_prev_reg;
    assign vsync_fall = ~vsync_reg & vsync_prev_reg;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (capture_en) state_next = SYNC;
            SYNC:    if (vsync_rise) state_next = ARMED;
            ARMED:   if (vsync_fall) state_next = CAPTURE;
            CAPTURE: if (vsync_rise) state_next = capture_en ? ARMED : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_capture    = (state_reg == CAPTURE);
        enter_capture = (state_reg == ARMED) && vsync_fall;
        close_frame   = (state_reg == CAPTURE) && vsync_rise;
    end

    // With DECIM=2 only even columns of even rows survive.
    generate
        if (DECIM == 1) begin : g_keep_all
            assign decim_ok = 1'b1;
        end else begin : g_keep_even
            assign decim_ok = ~col_reg[0] & ~row_reg[0];
        end
    endgenerate

    assign pix_done  = in_capture && bus.href && phase_reg;
    assign href_fall = in_capture && href_prev_reg && !bus.href;
    assign keep      = pix_done && (col_reg < COL_W'(SRC_W)) && (row_reg < ROW_W'(SRC_H)) && decim_ok;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_reg        <= 1'b0;
            vsync_prev_reg   <= 1'b0;
            href_prev_reg    <= 1'b0;
            phase_reg        <= 1'b0;
            byte0_reg        <= '0;
            col_reg          <= '0;
            row_reg          <= '0;
            wr_addr_reg      <= '0;
            wr_en_reg        <= 1'b0;
            full_reg         <= 1'b0;
            rgb_reg          <= '0;
            frame_done_reg   <= 1'b0;
            frame_active_reg <= 1'b0;
            line_err_reg     <= 1'b0;
            frame_count_reg  <= '0;
        end else begin
            vsync_reg        <= bus.vsync;
            vsync_prev_reg   <= vsync_reg;
            href_prev_reg    <= bus.href;
            frame_done_reg   <= close_frame;
            frame_active_reg <= (state_next == CAPTURE);
            wr_en_reg        <= 1'b0;

            phase_reg <= (in_capture && bus.href) ? ~phase_reg : 1'b0;
            // First byte keeps R4..R1 and G5..G3; R0 is dropped on the way in.
            if (in_capture && bus.href && !phase_reg)
                byte0_reg <= {bus.D[7:4], bus.D[2:0]};

            if (enter_capture) begin
                col_reg      <= '0;
                row_reg      <= '0;
                wr_addr_reg  <= '0;
                full_reg     <= 1'b0;
                line_err_reg <= 1'b0;
            end else begin
                if (wr_en_reg) begin
                    if (wr_addr_reg == LAST_ADDR) full_reg <= 1'b1;
                    else                          wr_addr_reg <= wr_addr_reg + ADDR_W'(1);
                end
                if (pix_done && col_reg != '1)
                    col_reg <= col_reg + COL_W'(1);
                if (keep) begin
                    if (full_reg) begin
                        line_err_reg <= 1'b1;
                    end else if (!bus.vsync && !vsync_reg) begin
                        wr_en_reg <= 1'b1;
                        rgb_reg   <= {byte0_reg, bus.D[7], bus.D[4:1]};
                    end
                end
                if (href_fall) begin
                    col_reg <= '0;
                    if (row_reg != '1) row_reg <= row_reg + ROW_W'(1);
                    if (col_reg != COL_W'(SRC_W)) line_err_reg <= 1'b1;
                end
                if (close_frame) begin
                    frame_count_reg <= frame_count_reg + 8'd1;
                    if (row_reg != ROW_W'(SRC_H)) line_err_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.RGB      = rgb_reg;
    assign bus.wr_addr  = wr_addr_reg;
    assign bus.wr_en    = wr_en_reg;
    assign frame_done   = frame_done_reg;
    assign frame_active = frame_active_reg;
    assign frame_count  = frame_count_reg;
    assign line_err     = line_err_reg;
endmodule

// File: tb/tb_ov7670_capture_decimator.sv
// Bench for ov7670_capture_decimator on a small 8x6 frame with DECIM=2.
// Expected writes are queued as bytes are driven and popped when wr_en appears.
module tb_ov7670_capture_decimator;
    localparam int W = 8, H = 6, DECIM = 2, ADDR_W = 4;
    localparam int FRAME_PIX = (W / DECIM) * (H / DECIM);
    localparam int NV = 10;

    logic pclk = 1'b0;
    logic rst_n = 1'b0;
    logic capture_en = 1'b0;
    logic frame_done, frame_active, line_err;
    logic [7:0] frame_count;

    ov7670_capture_decimator_if #(.ADDR_W(ADDR_W)) cam ();

    ov7670_capture_decimator #(.SRC_W(W), .SRC_H(H), .DECIM(DECIM), .ADDR_W(ADDR_W)) dut (
        .pclk(pclk), .rst_n(rst_n), .bus(cam), .capture_en(capture_en),
        .frame_done(frame_done), .frame_active(frame_active),
        .frame_count(frame_count), .line_err(line_err)
    );

    always #5 pclk = ~pclk;

    typedef struct { logic [15:0] px; logic [11:0] rgb; } vec_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [11:0] rgb; int cyc; } exp_t;

    vec_t vecs [NV];
    exp_t sb [$];
    exp_t got;
    int checks = 0, errors = 0;
    int cyc = 0, wr_seen = 0, wr_base = 0, done_cnt = 0;
    int exp_done = 0, exp_fc = 0, ramp_seed = 5;
    logic done_err = 1'b0, done_prev = 1'b0;
    logic [7:0] done_fc = '0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard side: every wr_en must match the oldest queued pixel.
    always @(negedge pclk) begin
        if (cam.wr_en) begin
            wr_seen++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write actual addr=%0d rgb=%h required none", cam.wr_addr, cam.RGB);
            end else begin
                got = sb.pop_front();
                chk("wr_addr", cam.wr_addr, got.addr);
                chk("rgb", cam.RGB, got.rgb);
                chk("wr_latency_cycle", cyc, got.cyc);
                $display("write addr=%0d rgb=%h cyc=%0d", cam.wr_addr, cam.RGB, cyc);
            end
        end
        if (frame_done) begin
            chk("done_pulse_width", done_prev, 0);
            done_cnt++;
            done_err = line_err;
            done_fc  = frame_count;
        end
        done_prev = frame_done;
    end

    task automatic vsync_pulse();
        cam.vsync = 1'b1;
        repeat (4) @(negedge pclk);
        cam.vsync = 1'b0;
        repeat (5) @(negedge pclk);
    endtask

    task automatic lines(input bit cap, input bit tbl, input int nrows, input int short_row,
                         input int odd_row, input int ce_row, input bit ce_val);
        int k, addr, npix;
        logic [15:0] px;
        logic [11:0] ex;
        bit keep;
        exp_t e;
        k = 0; addr = 0;
        for (int r = 0; r < nrows; r++) begin
            if (r == ce_row) capture_en = ce_val;
            npix = (r == short_row) ? W - 2 : W;
            for (int c = 0; c < npix; c++) begin
                keep = cap && (r < H) && (c % DECIM == 0) && (r % DECIM == 0);
                px = 16'((r * W + c) * 16'h0B57 + ramp_seed);
                ex = {px[15:12], px[10:7], px[4:1]};
                if (tbl && keep) begin
                    px = vecs[k % NV].px;
                    ex = vecs[k % NV].rgb;
                end
                cam.href = 1'b1;
                cam.D = px[15:8];
                @(negedge pclk);
                cam.D = px[7:0];
                if (keep) begin
                    k++;
                    if (addr < FRAME_PIX) begin
                        e.addr = ADDR_W'(addr); e.rgb = ex; e.cyc = cyc + 1;
                        sb.push_back(e);
                        addr++;
                    end
                end
                @(negedge pclk);
                if (r == 0 && c == 0) chk("frame_active", frame_active, cap);
            end
            if (r == odd_row) begin
                cam.D = 8'h5A;
                @(negedge pclk);
            end
            cam.href = 1'b0;
            cam.D = 8'($urandom);
            @(negedge pclk);
            if (r == short_row && cap) chk("line_err_short_line", line_err, 1);
            repeat (3) @(negedge pclk);
        end
        ramp_seed += 97;
    endtask

    task automatic close(input bit expect_done, input bit exp_err, input int exp_writes);
        vsync_pulse();
        if (expect_done) begin
            exp_done++;
            exp_fc = (exp_fc + 1) % 256;
        end
        chk("frame_done_count", done_cnt, exp_done);
        chk("frame_count", frame_count, exp_fc);
        chk("frame_writes", wr_seen - wr_base, exp_writes);
        if (expect_done) begin
            chk("line_err_at_done", done_err, exp_err);
            chk("frame_count_at_done", done_fc, exp_fc);
        end
        $display("frame closed done=%0d fc=%0d writes=%0d", done_cnt, frame_count, wr_seen - wr_base);
        wr_base = wr_seen;
    endtask

    initial begin
        vecs[0] = '{16'hF81F, 12'hF0F};
        vecs[1] = '{16'h07E0, 12'h0F0};
        vecs[2] = '{16'hFFFF, 12'hFFF};
        vecs[3] = '{16'h0000, 12'h000};
        vecs[4] = '{16'h8410, 12'h888};
        vecs[5] = '{16'h001F, 12'h00F};
        vecs[6] = '{16'hF800, 12'hF00};
        vecs[7] = '{16'h0021, 12'h000};
        vecs[8] = '{16'h7BEF, 12'h777};
        vecs[9] = '{16'hA554, 12'hAAA};
        cam.D = '0; cam.vsync = 1'b0; cam.href = 1'b0;

        // T1: reset held with a busy bus
        repeat (8) begin
            @(negedge pclk);
            cam.D = 8'($urandom);
            cam.href = 1'($urandom_range(0, 1));
            cam.vsync = 1'($urandom_range(0, 1));
            capture_en = 1'($urandom_range(0, 1));
        end
        @(negedge pclk);
        chk("rst_RGB", cam.RGB, 0);
        chk("rst_wr_addr", cam.wr_addr, 0);
        chk("rst_wr_en", cam.wr_en, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_active", frame_active, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_line_err", line_err, 0);
        cam.href = 1'b0; cam.vsync = 1'b0; capture_en = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge pclk);
        vsync_pulse();
        lines(0, 0, H, -1, -1, -1, 0);
        close(0, 0, 0);

        // T2: ramp frame after sync
        capture_en = 1'b1;
        repeat (3) @(negedge pclk);
        vsync_pulse();
        wr_base = wr_seen;
        lines(1, 0, H, -1, -1, -1, 0);
        close(1, 0, FRAME_PIX);

        // T3: colour table, odd trailing byte on row 1
        lines(1, 1, H, -1, 1, -1, 0);
        close(1, 0, FRAME_PIX);

        // T5: short kept line, then an extra line
        lines(1, 0, H, 2, -1, -1, 0);
        close(1, 1, FRAME_PIX - 1);
        chk("line_err_cleared_on_entry", line_err, 0);
        lines(1, 0, H + 1, -1, -1, -1, 0);
        close(1, 1, FRAME_PIX);

        // T6: capture_en dropped mid-frame
        lines(1, 0, H, -1, -1, 3, 0);
        close(1, 0, FRAME_PIX);
        chk("idle_after_drop", frame_active, 0);
        lines(0, 0, H, -1, -1, -1, 0);
        close(0, 0, 0);

        // T4: capture_en raised mid-frame
        lines(0, 0, H, -1, -1, 2, 1);
        close(0, 0, 0);
        lines(1, 0, H, -1, -1, -1, 0);
        close(1, 0, FRAME_PIX);

        // Reset in the middle of a captured frame
        lines(1, 0, 3, -1, -1, -1, 0);
        chk("pre_reset_writes", wr_seen - wr_base, 2 * (W / DECIM));
        wr_base = wr_seen;
        rst_n = 1'b0;
        @(negedge pclk);
        chk("midrst_wr_en", cam.wr_en, 0);
        chk("midrst_frame_count", frame_count, 0);
        chk("midrst_frame_active", frame_active, 0);
        chk("midrst_pending", sb.size(), 0);
        rst_n = 1'b1;
        exp_fc = 0;
        lines(0, 0, 3, -1, -1, -1, 0);
        close(0, 0, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
